hazard_stall: RTL
=================

HAZARD_STALL -- requirements
Module: hazard_stall

Interface
REQ-001 SHALL have parameter MD_LAT, default 32, meaning muldiv latency in cycles (legal 2..63).
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rs_id and rt_id, input, 5 each, source registers of the instruction in ID.
REQ-005 SHALL have port valid_id, input, 1, meaning ID holds a real instruction.
REQ-006 SHALL have port write_reg_id, input, 5, destination of the ID instruction.
REQ-007 SHALL have port cu_reg_write_id, input, 1, meaning the ID instruction writes a register.
REQ-008 SHALL have ports cu_mem_to_reg_id (load) and cu_muldiv_id (multiply/divide), input, 1 each.
REQ-009 SHALL have ports write_reg_wb (input, 5) and cu_reg_write_wb (input, 1), the writeback port.
REQ-010 SHALL have port branch_taken_ex, input, 1, a taken branch resolved in EX.
REQ-011 SHALL have ports stall_if, stall_id, flush_id and flush_ex, output, 1 each, pipeline controls.
REQ-012 SHALL have ports md_busy and md_done, output, 1 each, muldiv status; md_done is a 1-cycle pulse.
REQ-013 SHALL have port pending, output, 32, scoreboard vector; bit 0 is constant 0.

Function
REQ-014 Issue SHALL be defined as valid_id & !stall_id & !flush_id.
REQ-015 Track SHALL be defined as issue & cu_reg_write_id & (cu_mem_to_reg_id | cu_muldiv_id) & write_reg_id != 0.
REQ-016 Track SHALL set pending[write_reg_id] at the next edge; ALU results are forwarded and SHALL NOT be tracked.
REQ-017 cu_reg_write_wb & write_reg_wb != 0 SHALL clear pending[write_reg_wb] at the next edge.
REQ-018 Simultaneous set and clear of the same bit SHALL leave it set, because the new producer wins.
REQ-019 An operand SHALL be defined as hazardous when its register is != 0, its pending bit is 1, and it is not being cleared by WB this cycle; WB forwarding covers the cleared case, giving a zero-cycle release.
REQ-020 stall_id SHALL equal valid_id & !branch_taken_ex & (rs hazardous | rt hazardous | (cu_muldiv_id & md_busy)).
REQ-021 stall_if SHALL equal stall_id.
REQ-022 flush_id SHALL equal branch_taken_ex.
REQ-023 flush_ex SHALL equal branch_taken_ex | stall_id, inserting a bubble into EX.
REQ-024 The muldiv FSM SHALL have states IDLE and BUSY.
REQ-025 From IDLE, an issue with cu_muldiv_id SHALL go to BUSY and load the counter with MD_LAT-1.
REQ-026 In BUSY the counter SHALL decrement each cycle; at 0, md_done SHALL pulse and the FSM SHALL return to IDLE.
REQ-027 md_busy SHALL equal (state == BUSY).
REQ-028 A muldiv in ID while BUSY SHALL stall, including in the md_done cycle; it issues on the following cycle.
REQ-029 branch_taken_ex SHALL NOT abort a BUSY muldiv or clear any pending bit.
REQ-030 All outputs except pending, md_busy and md_done SHALL be combinational from inputs and state, with no added latency.

Reset
REQ-031 rst SHALL asynchronously force pending = 0, FSM = IDLE, counter = 0, and md_done = 0.
REQ-032 While rst is high, stall_if, stall_id, flush_id and flush_ex SHALL be 0 for any inputs.
REQ-033 Assertion of rst mid-muldiv SHALL abandon the operation with no md_done pulse.

Structure
REQ-034 MD_LAT default, counter width (6) and FSM state encodings SHALL live in the shared CPU package.
REQ-035 The muldiv latency FSM and counter SHALL be one sub-module, md_timer; scoreboard and stall logic stay in hazard_stall.

Verification
REQ-036 Load to r5 issues, next ID reads rs=5 -> stall_id=1 and flush_ex=1 until the WB cycle of r5, then stall_id=0 in that same cycle.
REQ-037 Muldiv to r8 with MD_LAT=4 -> md_busy=1 for 4 cycles, md_done pulses in the 4th; a dependent rt=8 stalls until WB clears r8.
REQ-038 Second muldiv in ID during BUSY -> stalled through the md_done cycle, issues the next cycle, counter reloads to 3.
REQ-039 branch_taken_ex=1 while ID holds a hazardous load-use -> stall_id=0, flush_id=1, flush_ex=1, and no pending bit set.
REQ-040 WB clears r3 while a new load to r3 issues in the same cycle -> pending[3] stays 1; a load to r0 never sets pending[0].
REQ-041 rst pulse during BUSY with pending = 0x0000_0120 -> pending = 0, md_busy = 0, no md_done, and all stalls 0.

Source files
------------

// File: rtl/hazard_stall_pkg.sv
// Shared pipeline-control definitions for the hazard/stall unit.
// Holds the default muldiv latency, the muldiv counter width/type and the
// muldiv FSM state encoding used by md_timer.
package hazard_stall_pkg;

    // Default multiply/divide latency in cycles (legal range 2..63).
    localparam int unsigned MdLatDefault = 32;

    // Width of the muldiv down-counter; must hold MD_LAT-1 for MD_LAT <= 63.
    localparam int unsigned MdCntW = 6;

    typedef logic [MdCntW-1:0] md_cnt_t;

    typedef enum logic [0:0] {
        MdIdle = 1'b0,
        MdBusy = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_timer.sv
// Multiply/divide latency tracker.
// A start request in IDLE loads the counter with MD_LAT-1 and enters BUSY.
// In BUSY the counter decrements each cycle; the cycle in which it reads 0 is
// the last busy cycle, raises done_o, and returns the FSM to IDLE.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (abandons any operation)
//   start_i  - issue of a muldiv instruction (only honoured in IDLE)
//   busy_o   - FSM is in BUSY
//   done_o   - one-cycle pulse in the final busy cycle
module md_timer
    import hazard_stall_pkg::*;
#(
    parameter int unsigned MD_LAT = MdLatDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    md_state_e state_q, state_d;
    md_cnt_t   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        unique case (state_q)
            MdIdle: begin
                if (start_i) begin
                    state_d = MdBusy;
                    cnt_d   = md_cnt_t'(MD_LAT - 1);
                end
            end
            MdBusy: begin
                if (cnt_q == '0) begin
                    // Done is derived from state, so an async reset kills it at once.
                    done_o  = 1'b1;
                    state_d = MdIdle;
                end else begin
                    cnt_d = cnt_q - md_cnt_t'(1);
                end
            end
            default: begin
                state_d = MdIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == MdBusy);

endmodule

// File: rtl/hazard_stall.sv
// Load-use / muldiv hazard detection and pipeline stall control.
// A scoreboard marks destination registers of in-flight loads and muldivs;
// ALU results are forwarded and never tracked. An ID operand that reads a
// pending register stalls IF/ID and bubbles EX, except when WB retires that
// register in the same cycle (WB forwarding gives a zero-cycle release).
// A second muldiv waits while the muldiv unit is busy.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   rs_id, rt_id                  - ID source registers
//   valid_id                      - ID holds a real instruction
//   write_reg_id, cu_reg_write_id - ID destination and write enable
//   cu_mem_to_reg_id, cu_muldiv_id- ID instruction is a load / muldiv
//   write_reg_wb, cu_reg_write_wb - writeback port
//   branch_taken_ex               - taken branch resolved in EX
//   stall_if, stall_id            - hold IF and ID
//   flush_id, flush_ex            - squash ID, bubble EX
//   md_busy, md_done              - muldiv status (done is a 1-cycle pulse)
//   pending                       - scoreboard, bit 0 always 0
module hazard_stall
    import hazard_stall_pkg::*;
#(
    parameter int unsigned MD_LAT = MdLatDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        valid_id,
    input  logic [4:0]  write_reg_id,
    input  logic        cu_reg_write_id,
    input  logic        cu_mem_to_reg_id,
    input  logic        cu_muldiv_id,
    input  logic [4:0]  write_reg_wb,
    input  logic        cu_reg_write_wb,
    input  logic        branch_taken_ex,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] pending
);

    logic [31:0] pending_q, pending_d;
    logic        wb_clear;
    logic        rs_hazard, rt_hazard;
    logic        issue, track;

    assign wb_clear = cu_reg_write_wb & (write_reg_wb != 5'd0);

    // A register being retired by WB this cycle is forwarded, not waited on.
    assign rs_hazard = (rs_id != 5'd0) & pending_q[rs_id] &
                       ~(wb_clear & (write_reg_wb == rs_id));
    assign rt_hazard = (rt_id != 5'd0) & pending_q[rt_id] &
                       ~(wb_clear & (write_reg_wb == rt_id));

    // Gated by rst so the controls read 0 throughout reset regardless of inputs.
    assign stall_id = ~rst & valid_id & ~branch_taken_ex &
                      (rs_hazard | rt_hazard | (cu_muldiv_id & md_busy));
    assign stall_if = stall_id;
    assign flush_id = ~rst & branch_taken_ex;
    assign flush_ex = flush_id | stall_id;

    assign issue = valid_id & ~stall_id & ~flush_id;
    assign track = issue & cu_reg_write_id & (cu_mem_to_reg_id | cu_muldiv_id) &
                   (write_reg_id != 5'd0);

    always_comb begin
        pending_d = pending_q;
        if (wb_clear) begin
            pending_d[write_reg_wb] = 1'b0;
        end
        // Applied after the clear so a new producer of the same register wins.
        if (track) begin
            pending_d[write_reg_id] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    md_timer #(
        .MD_LAT (MD_LAT)
    ) u_md_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (issue & cu_muldiv_id),
        .busy_o  (md_busy),
        .done_o  (md_done)
    );

endmodule
